// File: rtl/hazard_stall_if.sv
// Handshake bundle between the pipeline stages and the hazard/stall controller.
//   master : pipeline side - drives register IDs, load/branch/memory status,
//            observes the stall/flush controls and the counters.
//   slave  : controller side - the mirror image.
// Signals:
//   rs1_rr, rs2_rr, use_rs2_rr : source operands of the RR-stage instruction
//   rd_ex, memread_ex          : destination / load flag of the EX-stage instruction
//   branch_taken_ex            : branch or jump resolved taken in EX
//   mem_req_mem, mem_ready     : data-memory access handshake of the MEM stage
//   pc_en, ifrr_en, ifrr_flush, rrex_bubble, stall_all : pipeline controls
//   mem_err                    : sticky memory-timeout flag
//   stall_cnt, flush_cnt       : saturating performance counters
interface hazard_stall_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       rs1_rr;
  logic [4:0]       rs2_rr;
  logic             use_rs2_rr;
  logic [4:0]       rd_ex;
  logic             memread_ex;
  logic             branch_taken_ex;
  logic             mem_req_mem;
  logic             mem_ready;
  logic             pc_en;
  logic             ifrr_en;
  logic             ifrr_flush;
  logic             rrex_bubble;
  logic             stall_all;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1_rr, rs2_rr, use_rs2_rr, rd_ex, memread_ex, branch_taken_ex,
           mem_req_mem, mem_ready,
    input  pc_en, ifrr_en, ifrr_flush, rrex_bubble, stall_all, mem_err,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_rr, rs2_rr, use_rs2_rr, rd_ex, memread_ex, branch_taken_ex,
           mem_req_mem, mem_ready,
    output pc_en, ifrr_en, ifrr_flush, rrex_bubble, stall_all, mem_err,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall side of the bypass network for the 5-stage core. Holds the front of
// the pipeline on load-use hazards, squashes IF/RR on taken branches and
// freezes the back end while data memory is waiting (with a timeout that
// parks the controller in an absorbing error state).
// Ports:
//   clk   : pipeline clock, rising edge
//   rst_n : asynchronous active-low reset
//   hs    : hazard_stall_if slave modport (see interface for signal list)
// Parameters:
//   TIMEOUT_CYC : maximum consecutive memory-wait cycles (2..255)
//   CNT_W       : width of the saturating performance counters
module hazard_stall_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_stall_if.slave  hs
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             mem_err_q;

  logic             lu;
  logic             mem_stall;
  logic             freeze;
  logic             lu_stall;
  logic             flush_act;

  // Load-use detection; x0 never carries a real dependency.
  assign lu = hs.memread_ex && (hs.rd_ex != 5'd0) &&
              ((hs.rs1_rr == hs.rd_ex) ||
               (hs.use_rs2_rr && (hs.rs2_rr == hs.rd_ex)));

  assign mem_stall = hs.mem_req_mem && !hs.mem_ready;

  // State register and sequential bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      // Flag follows the state being entered so it rises on the same edge.
      mem_err_q   <= (state_d == ST_ERR);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (hs.mem_ready) begin
          state_d = ST_RUN;
        end else if (wait_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d = ST_ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Output logic: freeze > branch flush > load-use > run
  always_comb begin
    freeze         = (state_q == ST_ERR) || mem_stall;
    lu_stall       = 1'b0;
    flush_act      = 1'b0;
    hs.pc_en       = 1'b1;
    hs.ifrr_en     = 1'b1;
    hs.ifrr_flush  = 1'b0;
    hs.rrex_bubble = 1'b0;
    hs.stall_all   = 1'b0;
    if (freeze) begin
      // Pending branch/load-use stay put and are re-evaluated afterwards.
      hs.stall_all = 1'b1;
      hs.pc_en     = 1'b0;
      hs.ifrr_en   = 1'b0;
    end else if (hs.branch_taken_ex) begin
      // Flush wins over load-use: the consumer is being squashed anyway.
      flush_act      = 1'b1;
      hs.ifrr_flush  = 1'b1;
      hs.rrex_bubble = 1'b1;
    end else if (lu) begin
      lu_stall       = 1'b1;
      hs.pc_en       = 1'b0;
      hs.ifrr_en     = 1'b0;
      hs.rrex_bubble = 1'b1;
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((freeze || lu_stall) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_act && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  assign hs.mem_err   = mem_err_q;
  assign hs.stall_cnt = stall_cnt_q;
  assign hs.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 8;

  // Expected control pattern: {pc_en, ifrr_en, ifrr_flush, rrex_bubble, stall_all}
  localparam logic [4:0] NORM = 5'b11000;
  localparam logic [4:0] LUS  = 5'b00010;
  localparam logic [4:0] FLSH = 5'b11110;
  localparam logic [4:0] FRZ  = 5'b00001;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       req;
    logic       rdy;
    logic [4:0] exp;
  } vec_t;

  typedef struct {
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic          err;
  } cnt_t;

  logic clk;
  logic rst_n;

  hazard_stall_if #(.CNT_W(CW)) hs ();

  hazard_stall_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hs    (hs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [4:0] q_ctrl[$];
  cnt_t       q_cnt[$];
  logic [CW-1:0] m_sc;
  logic [CW-1:0] m_fc;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic use2, input logic [4:0] rd,
                              input logic mr, input logic br,
                              input logic req, input logic rdy,
                              input logic [4:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.use2 = use2; v.rd = rd;
    v.mr = mr; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    hs.rs1_rr          = v.rs1;
    hs.rs2_rr          = v.rs2;
    hs.use_rs2_rr      = v.use2;
    hs.rd_ex           = v.rd;
    hs.memread_ex      = v.mr;
    hs.branch_taken_ex = v.br;
    hs.mem_req_mem     = v.req;
    hs.mem_ready       = v.rdy;
  endtask

  // Called just after a rising edge: drive, check controls mid-cycle,
  // then check counters/mem_err after the following edge.
  task automatic step(input string nm, input vec_t v, input logic exp_err);
    logic [4:0] e;
    logic [4:0] got;
    cnt_t c;
    cnt_t g;
    drive(v);
    q_ctrl.push_back(v.exp);
    @(negedge clk);
    got = {hs.pc_en, hs.ifrr_en, hs.ifrr_flush, hs.rrex_bubble, hs.stall_all};
    e = q_ctrl.pop_front();
    chk({nm, ".ctrl"}, 32'(got), 32'(e));
    if (e[0] || (e[1] && !e[2])) begin
      if (m_sc != '1) m_sc = m_sc + 1'b1;
    end
    if (e[2]) begin
      if (m_fc != '1) m_fc = m_fc + 1'b1;
    end
    c.sc = m_sc; c.fc = m_fc; c.err = exp_err;
    q_cnt.push_back(c);
    @(posedge clk);
    #1;
    g = q_cnt.pop_front();
    chk({nm, ".stall_cnt"}, 32'(hs.stall_cnt), 32'(g.sc));
    chk({nm, ".flush_cnt"}, 32'(hs.flush_cnt), 32'(g.fc));
    chk({nm, ".mem_err"},   32'(hs.mem_err),   32'(g.err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t idle;
    vec_t v;
    idle = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    m_sc = '0;
    m_fc = '0;

    // Table: rs1 rs2 use2 rd mr br req rdy exp
    tbl.push_back(mk(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, NORM)); // idle
    tbl.push_back(mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LUS));  // lu rs1
    tbl.push_back(mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, NORM)); // bubble cleared load
    tbl.push_back(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NORM)); // x0
    tbl.push_back(mk(5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, NORM)); // rs2 unused
    tbl.push_back(mk(5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LUS));  // rs2 used
    tbl.push_back(mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, FLSH)); // branch over lu
    tbl.push_back(mk(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, FLSH)); // branch alone
    tbl.push_back(mk(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, NORM)); // zero-wait access
    tbl.push_back(mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, FRZ));  // wait 1, lu held
    tbl.push_back(mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, FRZ));  // wait 2
    tbl.push_back(mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, FRZ));  // wait 3
    tbl.push_back(mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, LUS));  // ready, lu applies
    tbl.push_back(mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, NORM)); // load gone
    tbl.push_back(mk(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, FRZ));  // branch held by wait
    tbl.push_back(mk(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, FLSH)); // branch released
    tbl.push_back(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM));

    // Reset state
    rst_n = 1'b0;
    drive(idle);
    #12;
    chk("rst.ctrl", 32'({hs.pc_en, hs.ifrr_en, hs.ifrr_flush, hs.rrex_bubble, hs.stall_all}), 32'(NORM));
    chk("rst.stall_cnt", 32'(hs.stall_cnt), 32'd0);
    chk("rst.flush_cnt", 32'(hs.flush_cnt), 32'd0);
    chk("rst.mem_err",   32'(hs.mem_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i], 1'b0);
    end

    // mem_ready on the last allowed WAIT cycle returns to RUN
    v = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ);
    for (int i = 0; i < int'(TO); i++) step($sformatf("edge_wait%0d", i), v, 1'b0);
    v.rdy = 1'b1; v.exp = NORM;
    step("edge_ready", v, 1'b0);

    // Timeout: error on the (TO+1)th edge after the request, sticky after
    v = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ);
    for (int i = 0; i < int'(TO); i++) step($sformatf("to_wait%0d", i), v, 1'b0);
    step("to_edge", v, 1'b1);
    v.rdy = 1'b1;
    step("err_ready", v, 1'b1);
    v = idle; v.exp = FRZ;
    step("err_idle", v, 1'b1);

    // Asynchronous reset in ERR, no clock edge involved
    drive(idle);
    rst_n = 1'b0;
    #1;
    m_sc = '0;
    m_fc = '0;
    chk("arst.mem_err",   32'(hs.mem_err),   32'd0);
    chk("arst.stall_cnt", 32'(hs.stall_cnt), 32'd0);
    chk("arst.flush_cnt", 32'(hs.flush_cnt), 32'd0);
    chk("arst.ctrl", 32'({hs.pc_en, hs.ifrr_en, hs.ifrr_flush, hs.rrex_bubble, hs.stall_all}), 32'(NORM));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counter saturation
    v = mk(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, LUS);
    for (int i = 0; i < 300; i++) step("sat_stall", v, 1'b0);
    chk("sat.stall_final", 32'(hs.stall_cnt), 32'hFF);
    v = mk(5'd1, 5'd0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, FLSH);
    for (int i = 0; i < 270; i++) step("sat_flush", v, 1'b0);
    chk("sat.flush_final", 32'(hs.flush_cnt), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard controller for the 5-stage core (IF, RR, EX, MEM, WB). It is the stall side of the bypass network: the forwarding unit resolves RAW hazards by muxing results forward, and this block holds the pipeline back when bypassing cannot help. It handles load-use hazards, taken-branch flushes and data-memory wait states. It sits beside the forwarding unit and drives the PC enable, the IF/RR and RR/EX register enables and clears, and the global freeze.

## Interface
Parameters:
- TIMEOUT_CYC, 64, maximum consecutive memory-wait cycles before the error state; legal range 2..255.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rs1_rr  in  5  source register 1 of the instruction in RR.
- rs2_rr  in  5  source register 2 of the instruction in RR.
- use_rs2_rr  in  1  RR instruction reads rs2 (R-type, branch, store).
- rd_ex  in  5  destination register of the instruction in EX.
- memread_ex  in  1  EX instruction is a load.
- branch_taken_ex  in  1  branch/jump resolved taken in EX.
- mem_req_mem  in  1  MEM stage has an active data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifrr_en  out  1  IF/RR register enable.
- ifrr_flush  out  1  IF/RR register synchronous clear.
- rrex_bubble  out  1  load a NOP into the RR/EX register.
- stall_all  out  1  freeze the EX/MEM and MEM/WB registers and the register-file write.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  count of cycles with any stall.
- flush_cnt  out  CNT_W  count of taken-branch flushes.

## Operation
- Load-use hazard: lu = memread_ex & (rd_ex != 0) & ((rs1_rr == rd_ex) | (use_rs2_rr & (rs2_rr == rd_ex))).
- Register x0 never creates a hazard.
- FSM states are RUN, WAIT and ERR. The state register resets to RUN.
- RUN → WAIT when mem_req_mem & ~mem_ready.
- WAIT → RUN when mem_ready.
- WAIT → ERR when the wait counter reaches TIMEOUT_CYC - 1 and mem_ready = 0.
- ERR is absorbing until reset.
- Wait counter (8-bit) clears in RUN and increments each cycle spent in WAIT.
- The output priority below is evaluated combinationally from the current state and current inputs.
  1. Freeze, when state is ERR, or when mem_req_mem & ~mem_ready:
     - stall_all = 1, pc_en = 0, ifrr_en = 0.
     - ifrr_flush = 0, rrex_bubble = 0.
     - A pending branch or load-use is held in place and re-evaluated once the freeze lifts.
  2. branch_taken_ex:
     - ifrr_flush = 1, rrex_bubble = 1, pc_en = 1, ifrr_en = 1.
     - The flush overrides lu, because the consumer is squashed anyway.
  3. lu:
     - pc_en = 0, ifrr_en = 0, rrex_bubble = 1.
     - Lasts exactly one cycle. The bubble clears memread_ex next cycle, and the load result is then forwarded from WB.
  4. Otherwise: pc_en = ifrr_en = 1 and all other outputs are 0.
- stall_cnt increments each cycle in which stall_all | lu-stall (case 3) is active.
- flush_cnt increments each cycle in which case 2 is active.
- Both counters saturate at all-ones and never wrap.
- mem_err = (state == ERR), registered.

## Timing
- Reset values:
  - State RUN, wait counter 0, stall_cnt = 0, flush_cnt = 0, mem_err = 0.
  - Combinational outputs with idle inputs: pc_en = 1, ifrr_en = 1, all others 0.
- Control outputs are zero-latency: they respond combinationally in the same cycle as the inputs.
- Counters and mem_err update on the clock edge following the qualifying cycle.
- Memory handshake: the access completes in the cycle where mem_req_mem & mem_ready. stall_all is 0 in that cycle.
- A zero-wait access (mem_ready = 1 in the first cycle) stays in RUN and causes no stall.
- Timeout boundary: with TIMEOUT_CYC = 64 and mem_ready held low, there are 64 WAIT cycles. mem_err rises at the 65th edge after the request.
  - mem_ready arriving on the 64th WAIT cycle still returns to RUN.
- Simultaneous branch_taken_ex and lu: only the flush is applied. stall_cnt is unchanged and flush_cnt increments by 1.
- Reset asserted mid-WAIT or mid-ERR: state, counters and mem_err clear immediately (asynchronously).

## Test plan
- Load-use detected: rd_ex = 5, memread_ex = 1, rs1_rr = 5 → one cycle with pc_en = 0, ifrr_en = 0, rrex_bubble = 1. Then memread_ex = 0 → normal operation. stall_cnt = 1.
- x0 and rs2 masking:
  - rd_ex = 0 with rs1_rr = 0 → no stall.
  - rd_ex = 7, rs2_rr = 7, use_rs2_rr = 0 → no stall.
  - Same with use_rs2_rr = 1 → stall.
- Branch over load-use: branch_taken_ex = 1 together with an lu condition → ifrr_flush = 1, rrex_bubble = 1, pc_en = 1. flush_cnt = 1, stall_cnt = 0.
- Memory wait of 3 cycles with an lu pending → stall_all = 1 for 3 cycles and no bubble during them. Then mem_ready → the lu stall is applied in the following cycle. stall_cnt = 4.
- Timeout: TIMEOUT_CYC = 4, mem_ready held low → mem_err = 1 after the 5th edge and stays 1 when mem_ready later rises. Asserting rst_n = 0 clears mem_err asynchronously.
- Saturation: force more than 65535 stall cycles → stall_cnt holds 16'hFFFF.
